uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Byte FIFO plus drain state machine between the controller's UART output (`o_data_uart` / `o_uart_tx_start`) and `UART_TX`.
- Lets the controller push I2C read results and status bytes back-to-back without polling `tx_busy_uart`.
- Paces `START` pulses to `UART_TX` from that block's `BUSY` handshake.
- Single clock domain (`clk`, system clock).

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries).
- DATA_W, 8, byte width.
- BUSY_TIMEOUT, 16, clk cycles to wait for `i_tx_busy` to rise after a launch before the byte is treated as sent.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- i_wr_en  in  1  push strobe from controller, one byte per cycle.
- i_wr_data  in  DATA_W  byte to push.
- o_full  out  1  count == DEPTH.
- o_empty  out  1  count == 0.
- o_level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- i_tx_busy  in  1  `BUSY` from UART_TX.
- o_tx_start  out  1  one-cycle `START` pulse to UART_TX.
- o_tx_data  out  DATA_W  `DATA` to UART_TX, registered.

Behaviour:
- Reset (`reset_n`=0 at posedge clk):
  - wr_ptr, rd_ptr, count = 0; state IDLE; timeout counter 0.
  - o_tx_start=0, o_tx_data=0, o_full=0, o_empty=1, o_level=0.
  - Reset mid-transfer discards queued bytes. Any byte already in UART_TX completes on its own; this block does not re-issue it.
- Storage: circular buffer of DEPTH entries. Pointers are DEPTH_LOG2 bits and wrap naturally from DEPTH-1 to 0. count is DEPTH_LOG2+1 bits.
- Write:
  - `i_wr_en` && !o_full at posedge: mem[wr_ptr] <= i_wr_data, wr_ptr++.
  - `i_wr_en` while o_full: byte dropped, no state change. This holds even if a pop happens in the same cycle, because full is taken from registered count.
- o_full, o_empty and o_level are combinational from registered count.
- Pop and push in the same cycle: count unchanged, both pointers advance.
- Drain FSM has states IDLE, WAIT_BUSY and WAIT_DONE.
  - IDLE → WAIT_BUSY when count != 0 && !i_tx_busy. On that edge:
    - o_tx_data <= mem[rd_ptr];
    - o_tx_start <= 1;
    - rd_ptr++, count--;
    - timeout counter cleared.
  - WAIT_BUSY:
    - o_tx_start <= 0, so the pulse lasts exactly one cycle.
    - If i_tx_busy=1, go to WAIT_DONE.
    - Otherwise the counter increments; when it reaches BUSY_TIMEOUT-1, go to IDLE.
  - WAIT_DONE: go to IDLE when i_tx_busy=0.
- o_tx_data holds stable from launch until the FSM returns to IDLE.
- Latency: a write sampled at edge k into an empty queue, with FSM IDLE and UART idle, gives o_tx_start=1 between edges k+1 and k+2. Data is not forwarded from the write port to the launch path.
- Minimum spacing between starts = 2 cycles + UART busy time + 1 cycle (IDLE re-evaluation).
- If i_tx_busy is already high in IDLE (for example after reset), no launch occurs until it drops.

Optional Feature:
- Macro: UART_TXQ_OVF_FLAG_EN.
- Defined:
  - Adds port `i_clr_ovf` (in, 1) and port `o_overflow` (out, 1).
  - o_overflow is a sticky flag, set on any dropped write, reset 0.
  - `i_clr_ovf` clears it. A drop in the same cycle as a clear wins, so the flag stays 1.
- Not defined: the ports are absent and drops are silent.

Decomposition:
- Shared package (`uart_pkg`) holds:
  - the txq_state_t encoding (IDLE=2'd0, WAIT_BUSY=2'd1, WAIT_DONE=2'd2);
  - default DEPTH_LOG2 and BUSY_TIMEOUT constants.
- One natural sub-module, `sync_fifo`, containing memory, pointers, count and flags; it is reusable for an RX-side queue.
- The drain FSM and timeout counter stay in `uart_tx_queue`.

Test Plan:
- Single byte: push 0xA5, UART model raises busy 3 cycles after start and holds it for 100 cycles → one o_tx_start pulse with o_tx_data=0xA5; o_empty=1 after launch; no second start.
- Burst and ordering: push 0x00..0x0F on 16 consecutive cycles → o_full=1 after the 16th push, o_level=16; bytes leave in order 0x00..0x0F, one start per busy cycle.
- Overflow: with the queue full, push 0xFF → byte dropped, o_level stays 16, 0xFF never transmitted. With UART_TXQ_OVF_FLAG_EN, o_overflow=1 until i_clr_ovf is pulsed.
- Timeout: busy held 0 permanently → after a push, FSM returns to IDLE 16 cycles after start; the next queued byte launches; exactly one start per byte.
- Wrap and simultaneous events: push 20 bytes while draining, interleaving push with pop in the same cycle → pointers wrap; o_level correct every cycle; output sequence matches input sequence.
- Reset mid-operation: 5 bytes queued, FSM in WAIT_DONE; assert reset_n=0 for 1 cycle → o_level=0, o_empty=1, o_tx_start=0, o_tx_data=0; no starts after UART busy falls.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: drain FSM encoding and default queue sizing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } txq_state_t;

    localparam int TXQ_DEPTH_LOG2   = 4;
    localparam int TXQ_DATA_W       = 8;
    localparam int TXQ_BUSY_TIMEOUT = 16;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: circular buffer with occupancy count and full/empty flags.
// Latency: a push sampled at edge k is readable on rd_dat_o after edge k (no write-to-read bypass).
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module sync_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_en_i,
    input  logic [DATA_W-1:0]     wr_dat_i,
    input  logic                  rd_en_i,
    output logic [DATA_W-1:0]     rd_dat_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

    logic [DATA_W-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push;
    logic                  pop;

    // Flags come from the registered count, so a same-cycle pop never frees room for a push.
    assign full_o   = (count_q == FULL_CNT);
    assign empty_o  = (count_q == '0);
    assign level_o  = count_q;
    assign rd_dat_o = mem_q[rd_ptr_q];

    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_dat_i;
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue that drains into UART_TX, pacing START pulses off BUSY; UART_TXQ_OVF_FLAG_EN adds a sticky overflow flag.
// Latency: byte pushed at edge k into an idle, empty queue launches (o_tx_start high) after edge k+1.
// Backpressure: none toward the writer; pushes while full are dropped. Launches wait for i_tx_busy low.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2   = TXQ_DEPTH_LOG2,
    parameter int DATA_W       = TXQ_DATA_W,
    parameter int BUSY_TIMEOUT = TXQ_BUSY_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_wr_en,
    input  logic [DATA_W-1:0]     i_wr_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level,
    input  logic                  i_tx_busy,
    output logic                  o_tx_start,
    output logic [DATA_W-1:0]     o_tx_data
`ifdef UART_TXQ_OVF_FLAG_EN
    ,
    input  logic                  i_clr_ovf,
    output logic                  o_overflow
`endif
);

    localparam int               TMO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    txq_state_t        state_q, state_d;
    logic              tx_start_q, tx_start_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rd_dat;

    sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en_i  (i_wr_en),
        .wr_dat_i (i_wr_data),
        .rd_en_i  (fifo_pop),
        .rd_dat_o (fifo_rd_dat),
        .full_o   (o_full),
        .empty_o  (o_empty),
        .level_o  (o_level)
    );

    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;

    always_comb begin
        state_d    = state_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        fifo_pop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!o_empty && !i_tx_busy) begin
                    fifo_pop   = 1'b1;
                    tx_data_d  = fifo_rd_dat;
                    tx_start_d = 1'b1;
                    tmo_cnt_d  = '0;
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                // A UART that never acknowledges must not wedge the queue.
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

`ifdef UART_TXQ_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (i_wr_en && o_full) begin
            ovf_d = 1'b1;
        end else if (i_clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural UART_TX busy model.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       o_full;
    logic       o_empty;
    logic [4:0] o_level;
    logic       i_tx_busy;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
`ifdef UART_TXQ_OVF_FLAG_EN
    logic       i_clr_ovf;
    logic       o_overflow;
`endif

    always #5 clk = ~clk;

    uart_tx_queue dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_level    (o_level),
        .i_tx_busy  (i_tx_busy),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
`ifdef UART_TXQ_OVF_FLAG_EN
        ,
        .i_clr_ovf  (i_clr_ovf),
        .o_overflow (o_overflow)
`endif
    );

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [7:0] sent[$];
    int         start_cyc[$];
    bit         uart_en    = 1'b0;
    bit         force_busy = 1'b0;
    int         busy_dly   = 3;
    int         busy_len   = 100;
    int         pend       = 0;
    int         hold       = 0;

    typedef struct {
        logic       wr;
        logic [7:0] dat;
        logic [4:0] lvl;
        logic       full;
        logic       empty;
        logic       start;
    } vec_t;
    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: advance, sample outputs #1 after the edge, then update the UART model.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (o_tx_start === 1'b1) begin
            sent.push_back(o_tx_data);
            start_cyc.push_back(cyc);
        end
        if (o_tx_start === 1'b1 && uart_en) begin
            pend = busy_dly;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) hold = busy_len;
        end else if (hold > 0) begin
            hold--;
        end
        i_tx_busy = force_busy || (hold > 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int         mlevel;
        int         n;
        logic       acc;
        logic [7:0] exp_q[$];
        int         p;

        reset_n   = 1'b0;
        i_wr_en   = 1'b0;
        i_wr_data = 8'h00;
        i_tx_busy = 1'b0;
`ifdef UART_TXQ_OVF_FLAG_EN
        i_clr_ovf = 1'b0;
`endif
        run(2);
        check("rst_level", o_level, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);
        check("rst_start", o_tx_start, 0);
        check("rst_data", o_tx_data, 0);
`ifdef UART_TXQ_OVF_FLAG_EN
        check("rst_ovf", o_overflow, 0);
`endif
        reset_n = 1'b1;
        run(1);

        // Single byte: latency, one-cycle pulse, data hold, no repeat.
        uart_en  = 1'b1;
        busy_dly = 3;
        busy_len = 100;
        sent.delete();
        i_wr_en   = 1'b1;
        i_wr_data = 8'hA5;
        tick();
        i_wr_en = 1'b0;
        check("single_lvl_after_push", o_level, 1);
        check("single_no_early_start", o_tx_start, 0);
        tick();
        check("single_start", o_tx_start, 1);
        check("single_data", o_tx_data, 8'hA5);
        check("single_empty_after_launch", o_empty, 1);
        tick();
        check("single_pulse_width", o_tx_start, 0);
        check("single_data_hold", o_tx_data, 8'hA5);
        run(120);
        check("single_start_count", sent.size(), 1);
        if (sent.size() >= 1) check("single_sent", sent[0], 8'hA5);

        // Burst into a busy UART, then overflow; table-driven.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{wr: 1'b1, dat: 8'(i), lvl: 5'(i + 1), full: (i == 15), empty: 1'b0, start: 1'b0};
        end
        vecs[16] = '{wr: 1'b1, dat: 8'hFF, lvl: 5'd16, full: 1'b1, empty: 1'b0, start: 1'b0};
        vecs[17] = '{wr: 1'b0, dat: 8'h00, lvl: 5'd16, full: 1'b1, empty: 1'b0, start: 1'b0};
        force_busy = 1'b1;
        i_tx_busy  = 1'b1;
        sent.delete();
        for (int i = 0; i < 18; i++) begin
            i_wr_en   = vecs[i].wr;
            i_wr_data = vecs[i].dat;
            tick();
            check($sformatf("burst%0d_level", i), o_level, vecs[i].lvl);
            check($sformatf("burst%0d_full", i), o_full, vecs[i].full);
            check($sformatf("burst%0d_empty", i), o_empty, vecs[i].empty);
            check($sformatf("burst%0d_start", i), o_tx_start, vecs[i].start);
        end
        i_wr_en = 1'b0;
`ifdef UART_TXQ_OVF_FLAG_EN
        check("ovf_set", o_overflow, 1);
        i_clr_ovf = 1'b1;
        i_wr_en   = 1'b1;
        i_wr_data = 8'hFF;
        tick();
        check("ovf_drop_beats_clear", o_overflow, 1);
        check("ovf_level_held", o_level, 16);
        i_wr_en = 1'b0;
        tick();
        check("ovf_cleared", o_overflow, 0);
        i_clr_ovf = 1'b0;
`endif
        force_busy = 1'b0;
        busy_dly   = 2;
        busy_len   = 5;
        run(400);
        check("burst_sent_count", sent.size(), 16);
        for (int i = 0; i < 16 && i < sent.size(); i++) begin
            check($sformatf("burst_order%0d", i), sent[i], 8'(i));
        end
        check("burst_drained", o_empty, 1);

        // Timeout: UART never raises busy.
        uart_en = 1'b0;
        sent.delete();
        start_cyc.delete();
        i_wr_en   = 1'b1;
        i_wr_data = 8'h3C;
        tick();
        p = cyc;
        i_wr_data = 8'hC3;
        tick();
        i_wr_en = 1'b0;
        run(60);
        check("tmo_start_count", sent.size(), 2);
        if (sent.size() == 2) begin
            check("tmo_data0", sent[0], 8'h3C);
            check("tmo_data1", sent[1], 8'hC3);
            check("tmo_first_latency", start_cyc[0] - p, 1);
            check("tmo_spacing", start_cyc[1] - start_cyc[0], 17);
        end

        // Wrap with pushes overlapping pops; level conserved every cycle.
        uart_en  = 1'b1;
        busy_dly = 1;
        busy_len = 2;
        sent.delete();
        exp_q.delete();
        mlevel = 0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            i_wr_en   = (i % 3 != 2);
            i_wr_data = 8'(8'h40 + n);
            acc = i_wr_en && (mlevel < 16);
            if (i_wr_en) n++;
            if (acc) exp_q.push_back(i_wr_data);
            tick();
            mlevel = mlevel + (acc ? 1 : 0) - (o_tx_start ? 1 : 0);
            check($sformatf("wrap_level%0d", i), o_level, mlevel);
        end
        i_wr_en = 1'b0;
        run(300);
        check("wrap_sent_count", sent.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent.size(); i++) begin
            check($sformatf("wrap_order%0d", i), sent[i], exp_q[i]);
        end

        // Reset while WAIT_DONE with 5 bytes queued.
        busy_dly = 1;
        busy_len = 50;
        for (int i = 0; i < 6; i++) begin
            i_wr_en   = 1'b1;
            i_wr_data = 8'(8'h90 + i);
            tick();
        end
        i_wr_en = 1'b0;
        check("mid_level_before_rst", o_level, 5);
        check("mid_busy_seen", i_tx_busy, 1);
        sent.delete();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_level", o_level, 0);
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_start", o_tx_start, 0);
        check("mid_rst_data", o_tx_data, 0);
        run(80);
        check("mid_no_restart", sent.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
